vga_rx: RTL

Passive receiver for the VGA timing the raster renderer drives (640x480, negative sync, 6-bit RGB). It samples `hsync_n`/`vsync_n`/`rgb` in the pixel-clock domain and recovers pixel coordinates. It checks line and frame timing, locks after one clean frame, and then emits one strobe per visible pixel. It sits beside the renderer top level in simulation and on-FPGA self-test, for frame capture, CRC and regression checking.

---
 rtl/vga_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx.sv
// vga_rx: passive VGA timing receiver. Registers the sync/colour pins once,
// recovers line/frame position from the sync edges, checks the timing against
// the configured raster, locks after one clean frame and then strobes out
// every visible pixel with its coordinates and colour.
module vga_rx #(
   parameter int H_VIEW  = 640,
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_TOTAL = 800,
   parameter int V_VIEW  = 480,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_TOTAL = 525
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       hsync_n,
   input  logic       vsync_n,
   input  logic [5:0] rgb,
   output logic       o_locked,
   output logic       o_px_valid,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic [5:0] o_rgb,
   output logic       o_frame_start,
   output logic       o_err,
   output logic [7:0] o_err_count
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} rxState_t;

   localparam logic [10:0] hSyncW    = 11'(H_SYNC);
   localparam logic [10:0] hTotalW   = 11'(H_TOTAL);
   localparam logic [10:0] hVisStart = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] hVisEnd   = 11'(H_SYNC + H_BACK + H_VIEW);
   localparam logic [10:0] vTotalW   = 11'(V_TOTAL);
   localparam logic [10:0] vVisStart = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] vVisEnd   = 11'(V_SYNC + V_BACK + V_VIEW);

   logic        r_sHsyncN;
   logic        r_sVsyncN;
   logic [5:0]  r_sRgb;
   logic        r_prevHsyncN;
   logic        r_vsyncAtFall;
   logic        r_lineSeen;
   logic        r_lateFlagged;
   logic        r_dirty;
   logic [10:0] r_hCount;
   logic [10:0] r_vCount;
   rxState_t    r_state;
   rxState_t    w_stateNext;

   logic        r_pxValid;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [5:0]  r_rgb;
   logic        r_frameStart;
   logic        r_err;
   logic [7:0]  r_errCount;

   logic        w_hFall;
   logic        w_hRise;
   logic        w_vStart;
   logic [10:0] w_hNext;
   logic [10:0] w_hCur;
   logic [10:0] w_vNext;
   logic [10:0] w_vCur;
   logic        w_e1;
   logic        w_e2;
   logic        w_e3;
   logic        w_e4;
   logic        w_err;
   logic        w_visible;
   logic        w_pxValid;

   // Edge detection and position of the sample currently held in the s_* registers
   assign w_hFall  = ~r_sHsyncN & r_prevHsyncN;
   assign w_hRise  = r_sHsyncN & ~r_prevHsyncN;
   assign w_vStart = w_hFall & ~r_sVsyncN & r_vsyncAtFall;
   assign w_hNext  = (r_hCount == 11'h7FF) ? r_hCount : r_hCount + 11'd1;
   assign w_hCur   = w_hFall ? 11'd0 : w_hNext;
   assign w_vNext  = (r_vCount == 11'h7FF) ? r_vCount : r_vCount + 11'd1;
   assign w_vCur   = w_vStart ? 11'd0 : (w_hFall ? w_vNext : r_vCount);

   // Timing checks; the previous line length is the last h plus one, and a
   // late fall after a missing-fall flag is not reported a second time
   always_comb begin
      w_e1 = w_hFall & r_lineSeen & ~r_lateFlagged & (w_hNext != hTotalW);
      w_e2 = w_hRise & (w_hCur != hSyncW);
      w_e3 = w_vStart & (w_vNext != vTotalW);
      w_e4 = ~w_hFall & r_lineSeen & (w_hNext == hTotalW);
      w_err = (r_state != HUNT) & (w_e1 | w_e2 | w_e3 | w_e4);
      w_visible = (w_hCur >= hVisStart) && (w_hCur < hVisEnd) &&
                  (w_vCur >= vVisStart) && (w_vCur < vVisEnd);
      w_pxValid = (r_state == LOCKED) && w_visible;
   end

   // Single input register stage; idle-high syncs so reset never looks like an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sHsyncN <= 1'b1;
         r_sVsyncN <= 1'b1;
         r_sRgb    <= 6'd0;
      end else begin
         r_sHsyncN <= hsync_n;
         r_sVsyncN <= vsync_n;
         r_sRgb    <= rgb;
      end
   end

   // Line/frame counters plus the history needed for edge and vsync-start detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prevHsyncN  <= 1'b1;
         r_vsyncAtFall <= 1'b1;
         r_lineSeen    <= 1'b0;
         r_lateFlagged <= 1'b0;
         r_hCount      <= 11'd0;
         r_vCount      <= 11'd0;
      end else begin
         r_prevHsyncN <= r_sHsyncN;
         r_hCount     <= w_hCur;
         r_vCount     <= w_vCur;
         if (w_hFall) begin
            r_vsyncAtFall <= r_sVsyncN;
            r_lineSeen    <= 1'b1;
            r_lateFlagged <= 1'b0;
         end else if (w_e4) begin
            r_lateFlagged <= 1'b1;
         end
      end
   end

   // Remembers a violation seen since the last vsync start while acquiring sync
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dirty <= 1'b0;
      end else if (w_vStart) begin
         r_dirty <= 1'b0;
      end else if (w_err) begin
         r_dirty <= 1'b1;
      end
   end

   // Lock state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Lock progression; a violation always takes priority over a vsync start
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         HUNT: begin
            if (w_vStart) begin
               w_stateNext = SYNC;
            end
         end
         SYNC: begin
            if (!w_err && w_vStart && !r_dirty) begin
               w_stateNext = LOCKED;
            end
         end
         LOCKED: begin
            if (w_err) begin
               w_stateNext = HUNT;
            end
         end
         default: w_stateNext = HUNT;
      endcase
   end

   // Output stage: strobes, held pixel data and the saturating violation count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pxValid    <= 1'b0;
         r_x          <= 10'd0;
         r_y          <= 10'd0;
         r_rgb        <= 6'd0;
         r_frameStart <= 1'b0;
         r_err        <= 1'b0;
         r_errCount   <= 8'd0;
      end else begin
         r_pxValid    <= w_pxValid;
         r_frameStart <= w_vStart;
         r_err        <= w_err;
         if (w_pxValid) begin
            r_x   <= 10'(w_hCur - hVisStart);
            r_y   <= 10'(w_vCur - vVisStart);
            r_rgb <= r_sRgb;
         end
         if (w_err && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
         end
      end
   end

   assign o_locked      = (r_state == LOCKED);
   assign o_px_valid    = r_pxValid;
   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_rgb         = r_rgb;
   assign o_frame_start = r_frameStart;
   assign o_err         = r_err;
   assign o_err_count   = r_errCount;

endmodule
